// File: rtl/dircc_stream_mem_loader.sv
// rtl/dircc_stream_mem_loader.sv - Avalon-ST packet sink writing halfwords into a linear local-memory buffer
// Optional macro DIRCC_PKT_HEADER_EN: reserve the first buffer halfword for the packet length header.
module dircc_stream_mem_loader #(
   parameter int ADDR_W = 15,
   parameter int LEN_W  = 15
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic [ADDR_W-1:0] buf_base,
   input  logic [LEN_W-1:0]  buf_words,
   input  logic              stream_in_valid,
   input  logic [31:0]       stream_in_data,
   input  logic              stream_in_startofpacket,
   input  logic              stream_in_endofpacket,
   input  logic [1:0]        stream_in_empty,
   output logic              stream_in_ready,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_chipselect,
   output logic              mem_clken,
   output logic              mem_write,
   output logic [15:0]       mem_writedata,
   output logic [1:0]        mem_byteenable,
   output logic              pkt_done,
   output logic [LEN_W-1:0]  pkt_len,
   output logic              pkt_overflow,
   output logic              pkt_abort
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WR_HI = 3'd1;
   localparam logic [2:0] S_WR_LO = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_FIN   = 3'd4;
`ifdef DIRCC_PKT_HEADER_EN
   localparam logic [2:0] S_HDR   = 3'd5;
   // Packet end detours through the header write before reporting completion
   localparam logic [2:0] S_END   = S_HDR;
   localparam int         HDR_OFS = 1;
`else
   localparam logic [2:0] S_END   = S_FIN;
   localparam int         HDR_OFS = 0;
`endif

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [LEN_W-1:0]  cap_q, cap_d;
   logic [LEN_W-1:0]  off_q, off_d;
   logic              ovf_q, ovf_d;
   logic [31:0]       data_q, data_d;
   logic              eop_q, eop_d;
   logic [1:0]        empty_q, empty_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic              povf_q, povf_d;
   logic              take;
   logic              wr_ok;
   logic [LEN_W-1:0]  cap_in;

`ifdef DIRCC_PKT_HEADER_EN
   // One halfword goes to the header; a zero-size buffer still leaves no payload room
   assign cap_in = (buf_words == '0) ? '0 : buf_words - LEN_W'(1);
`else
   assign cap_in = buf_words;
`endif

   assign wr_ok          = (off_q < cap_q);
   assign mem_clken      = mem_chipselect;
   assign mem_write      = mem_chipselect;
   assign pkt_len        = len_q;
   assign pkt_overflow   = povf_q;

   // Next-state, handshake and memory-strobe decode
   always_comb begin
      state_d         = state_q;
      base_d          = base_q;
      cap_d           = cap_q;
      off_d           = off_q;
      ovf_d           = ovf_q;
      data_d          = data_q;
      eop_d           = eop_q;
      empty_d         = empty_q;
      len_d           = len_q;
      povf_d          = povf_q;
      stream_in_ready = 1'b0;
      mem_chipselect  = 1'b0;
      mem_address     = '0;
      mem_writedata   = '0;
      mem_byteenable  = 2'b00;
      pkt_done        = 1'b0;
      pkt_abort       = 1'b0;
      take            = 1'b0;

      case (state_q)
         S_IDLE: begin
            stream_in_ready = 1'b1;
         end
         S_WR_HI: begin
            mem_writedata  = data_q[31:16];
            mem_byteenable = (eop_q && empty_q == 2'd3) ? 2'b10 : 2'b11;
            if (wr_ok) begin
               mem_chipselect = 1'b1;
               mem_address    = base_q + ADDR_W'(HDR_OFS) + ADDR_W'(off_q);
               off_d          = off_q + LEN_W'(1);
            end else begin
               ovf_d = 1'b1;
            end
            state_d = (eop_q && empty_q >= 2'd2) ? S_END : S_WR_LO;
         end
         S_WR_LO: begin
            mem_writedata  = data_q[15:0];
            mem_byteenable = (eop_q && empty_q == 2'd1) ? 2'b10 : 2'b11;
            if (wr_ok) begin
               mem_chipselect = 1'b1;
               mem_address    = base_q + ADDR_W'(HDR_OFS) + ADDR_W'(off_q);
               off_d          = off_q + LEN_W'(1);
            end else begin
               ovf_d = 1'b1;
            end
            if (eop_q) begin
               state_d = S_END;
            end else begin
               stream_in_ready = 1'b1;
               state_d         = S_WAIT;
            end
         end
         S_WAIT: begin
            stream_in_ready = 1'b1;
         end
`ifdef DIRCC_PKT_HEADER_EN
         S_HDR: begin
            mem_chipselect = 1'b1;
            mem_address    = base_q;
            mem_writedata  = 16'(off_q);
            mem_byteenable = 2'b11;
            state_d        = S_FIN;
         end
`endif
         S_FIN: begin
            pkt_done = 1'b1;
            state_d  = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Beat acceptance is shared by every state that offers ready
      take = stream_in_valid && stream_in_ready;
      if (take) begin
         if (stream_in_startofpacket) begin
            pkt_abort = (state_q == S_WR_LO) || (state_q == S_WAIT);
            base_d    = buf_base;
            cap_d     = cap_in;
            off_d     = '0;
            ovf_d     = 1'b0;
            data_d    = stream_in_data;
            eop_d     = stream_in_endofpacket;
            empty_d   = stream_in_empty;
            state_d   = S_WR_HI;
         end else if (state_q != S_IDLE) begin
            data_d    = stream_in_data;
            eop_d     = stream_in_endofpacket;
            empty_d   = stream_in_empty;
            state_d   = S_WR_HI;
         end
      end

      // Length and overflow are published as the packet enters FIN
      if (state_d == S_FIN && state_q != S_FIN) begin
         len_d  = off_d;
         povf_d = ovf_d;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q <= S_IDLE;
         base_q  <= '0;
         cap_q   <= '0;
         off_q   <= '0;
         ovf_q   <= 1'b0;
         data_q  <= '0;
         eop_q   <= 1'b0;
         empty_q <= 2'b00;
         len_q   <= '0;
         povf_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         cap_q   <= cap_d;
         off_q   <= off_d;
         ovf_q   <= ovf_d;
         data_q  <= data_d;
         eop_q   <= eop_d;
         empty_q <= empty_d;
         len_q   <= len_d;
         povf_q  <= povf_d;
      end
   end

endmodule
